// File: rtl/cronometro_pkg.sv
// Shared types and helpers for the stopwatch control unit.
package cronometro_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } crono_state_t;

    localparam int unsigned LAP_W = 2;

    // Lap write pointer advance; the oldest slot is reused after the last one.
    function automatic logic [LAP_W-1:0] lap_ptr_next(
        input logic [LAP_W-1:0] ptr,
        input logic [LAP_W-1:0] last
    );
        return (ptr == last) ? '0 : LAP_W'(ptr + LAP_W'(1));
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Raw active-low key: 2-FF synchroniser, debounce filter and one-cycle press pulse.
module key_debounce #(
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int unsigned   CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_deb;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;

    // Debounced level follows the synchronised level only after DEB_CYCLES unbroken cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta  <= 1'b1;
            r_sync  <= 1'b1;
            r_deb   <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_meta  <= key_n;
            r_sync  <= r_meta;
            r_press <= 1'b0;
            if (r_sync == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_deb   <= r_sync;
                r_press <= ~r_sync;
            end else begin
                r_cnt <= CNT_W'(r_cnt + CNT_W'(1));
            end
        end
    end

    assign press = r_press;

endmodule

// File: rtl/cronometro_ctrl.sv
// Stopwatch control: key conditioning, IDLE/RUN/STOP sequencing, centisecond tick,
// lap write strobes and display view validation.
module cronometro_ctrl
    import cronometro_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 500000,
    parameter int unsigned DEB_CYCLES = 1000000,
    parameter int unsigned N_LAPS     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_ss_n,
    input  logic             key_lap_n,
    input  logic             key_clr_n,
    input  logic [LAP_W-1:0] sw_view,
    output logic             tick,
    output logic             cnt_clr,
    output logic             lap_we,
    output logic [LAP_W-1:0] lap_idx,
    output logic [LAP_W-1:0] lap_cnt,
    output logic [LAP_W-1:0] disp_sel,
    output logic             running
);

    localparam int unsigned      PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [LAP_W-1:0] LAP_MAX  = LAP_W'(N_LAPS);
    localparam logic [LAP_W-1:0] LAP_LAST = LAP_W'(N_LAPS - 1);

    logic w_ss_p;
    logic w_lap_p;
    logic w_clr_p;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ss (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_ss_n),
        .press (w_ss_p)
    );

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lap (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_lap_n),
        .press (w_lap_p)
    );

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_clr_n),
        .press (w_clr_p)
    );

    crono_state_t     r_state;
    logic [PRE_W-1:0] r_presc;
    logic [LAP_W-1:0] r_wptr;
    logic             r_tick;
    logic             r_cnt_clr;
    logic             r_lap_we;
    logic [LAP_W-1:0] r_lap_idx;
    logic [LAP_W-1:0] r_lap_cnt;
    logic [LAP_W-1:0] r_disp_sel;
    logic             r_running;

    crono_state_t     w_state_nxt;
    logic [PRE_W-1:0] w_presc_nxt;
    logic [LAP_W-1:0] w_wptr_nxt;
    logic             w_tick_nxt;
    logic             w_cnt_clr_nxt;
    logic             w_lap_we_nxt;
    logic [LAP_W-1:0] w_lap_idx_nxt;
    logic [LAP_W-1:0] w_lap_cnt_nxt;
    logic [LAP_W-1:0] w_disp_sel_nxt;
    logic             w_running_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_presc    <= '0;
            r_wptr     <= '0;
            r_tick     <= 1'b0;
            r_cnt_clr  <= 1'b0;
            r_lap_we   <= 1'b0;
            r_lap_idx  <= '0;
            r_lap_cnt  <= '0;
            r_disp_sel <= '0;
            r_running  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_presc    <= w_presc_nxt;
            r_wptr     <= w_wptr_nxt;
            r_tick     <= w_tick_nxt;
            r_cnt_clr  <= w_cnt_clr_nxt;
            r_lap_we   <= w_lap_we_nxt;
            r_lap_idx  <= w_lap_idx_nxt;
            r_lap_cnt  <= w_lap_cnt_nxt;
            r_disp_sel <= w_disp_sel_nxt;
            r_running  <= w_running_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_presc_nxt   = r_presc;
        w_wptr_nxt    = r_wptr;
        w_cnt_clr_nxt = 1'b0;
        w_lap_we_nxt  = 1'b0;
        w_lap_idx_nxt = r_lap_idx;
        w_lap_cnt_nxt = r_lap_cnt;

        case (r_state)
            IDLE: begin
                if (w_ss_p) w_state_nxt = RUN;
            end
            RUN: begin
                if (w_ss_p) w_state_nxt = STOP;
                // A lap press coinciding with stop is still captured.
                if (w_lap_p) begin
                    w_lap_we_nxt  = 1'b1;
                    w_lap_idx_nxt = r_wptr;
                    w_wptr_nxt    = lap_ptr_next(r_wptr, LAP_LAST);
                    if (r_lap_cnt < LAP_MAX) w_lap_cnt_nxt = LAP_W'(r_lap_cnt + LAP_W'(1));
                end
            end
            STOP: begin
                if (w_ss_p) begin
                    w_state_nxt = RUN;
                end else if (w_clr_p) begin
                    w_state_nxt   = IDLE;
                    w_cnt_clr_nxt = 1'b1;
                    w_wptr_nxt    = '0;
                    w_lap_idx_nxt = '0;
                    w_lap_cnt_nxt = '0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Prescaler advances in RUN, freezes in STOP, is pinned to zero in IDLE.
        if (w_state_nxt == IDLE) begin
            w_presc_nxt = '0;
        end else if (r_state == RUN) begin
            w_presc_nxt = (r_presc == PRE_LAST) ? '0 : PRE_W'(r_presc + PRE_W'(1));
        end

        w_tick_nxt     = (w_state_nxt == RUN) && (w_presc_nxt == PRE_LAST);
        w_running_nxt  = (w_state_nxt == RUN);
        w_disp_sel_nxt = (sw_view <= r_lap_cnt) ? sw_view : '0;
    end

    assign tick     = r_tick;
    assign cnt_clr  = r_cnt_clr;
    assign lap_we   = r_lap_we;
    assign lap_idx  = r_lap_idx;
    assign lap_cnt  = r_lap_cnt;
    assign disp_sel = r_disp_sel;
    assign running  = r_running;

endmodule

// File: tb/tb_cronometro_ctrl.sv
// Directed bench for cronometro_ctrl with TICK_DIV=10, DEB_CYCLES=4.
module tb_cronometro_ctrl;

    logic       clk;
    logic       rst_n;
    logic       key_ss_n;
    logic       key_lap_n;
    logic       key_clr_n;
    logic [1:0] sw_view;
    logic       tick;
    logic       cnt_clr;
    logic       lap_we;
    logic [1:0] lap_idx;
    logic [1:0] lap_cnt;
    logic [1:0] disp_sel;
    logic       running;

    int n_checks;
    int n_errors;

    int mon_we;
    int mon_clr;
    int mon_tick;
    int run_rise_at;
    int run_fall_at;
    int first_tick_at;
    int we_idx;
    int we_cnt;
    int run_at_we;

    cronometro_ctrl #(
        .TICK_DIV   (10),
        .DEB_CYCLES (4),
        .N_LAPS     (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_ss_n  (key_ss_n),
        .key_lap_n (key_lap_n),
        .key_clr_n (key_clr_n),
        .sw_view   (sw_view),
        .tick      (tick),
        .cnt_clr   (cnt_clr),
        .lap_we    (lap_we),
        .lap_idx   (lap_idx),
        .lap_cnt   (lap_cnt),
        .disp_sel  (disp_sel),
        .running   (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int all_outs();
        return int'({tick, cnt_clr, lap_we, lap_idx, lap_cnt, disp_sel, running});
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        key_ss_n  = 1'b1;
        key_lap_n = 1'b1;
        key_clr_n = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge: press the selected keys, hold 10 cycles, watch outputs for span cycles.
    task automatic press_keys(input bit ss, input bit lap, input bit clr, input int span);
        logic prev_run;
        mon_we        = 0;
        mon_clr       = 0;
        mon_tick      = 0;
        run_rise_at   = -1;
        run_fall_at   = -1;
        first_tick_at = -1;
        we_idx        = -1;
        we_cnt        = -1;
        run_at_we     = -1;
        prev_run      = running;
        key_ss_n      = ~ss;
        key_lap_n     = ~lap;
        key_clr_n     = ~clr;
        for (int i = 1; i <= span; i++) begin
            @(negedge clk);
            if (lap_we) begin
                mon_we++;
                we_idx    = int'(lap_idx);
                we_cnt    = int'(lap_cnt);
                run_at_we = int'(running);
            end
            if (cnt_clr) mon_clr++;
            if (tick) begin
                mon_tick++;
                if (first_tick_at < 0) first_tick_at = i;
            end
            if (running && !prev_run && run_rise_at < 0) run_rise_at = i;
            if (!running && prev_run && run_fall_at < 0) run_fall_at = i;
            prev_run = running;
            if (i == 10) begin
                key_ss_n  = 1'b1;
                key_lap_n = 1'b1;
                key_clr_n = 1'b1;
            end
        end
    endtask

    initial begin
        int wait_cyc;
        int bounce_run;
        int exp_idx [4];
        int exp_cnt [4];
        exp_idx = '{0, 1, 2, 0};
        exp_cnt = '{1, 2, 3, 3};
        n_checks = 0;
        n_errors = 0;
        sw_view  = 2'd0;

        // Reset state
        rst_n     = 1'b0;
        key_ss_n  = 1'b1;
        key_lap_n = 1'b1;
        key_clr_n = 1'b1;
        #1;
        check_eq("reset_outs", all_outs(), 0);
        do_reset();
        check_eq("post_reset_outs", all_outs(), 0);

        // 1: start, tick cadence
        press_keys(1, 0, 0, 56);
        check_eq("t1_run_rise", run_rise_at, 7);
        check_eq("t1_first_tick", first_tick_at, 16);
        check_eq("t1_tick_count", mon_tick, 5);

        // 4: stop with prescaler parked at 6, resume
        wait_cyc = 0;
        while (!tick && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        check_eq("t4_tick_found", int'(tick), 1);
        press_keys(1, 0, 0, 40);
        check_eq("t4_run_fall", run_fall_at, 7);
        check_eq("t4_no_tick_stopped", mon_tick, 0);
        press_keys(1, 0, 0, 20);
        check_eq("t4_resume_rise", run_rise_at, 7);
        check_eq("t4_resume_tick", first_tick_at, 10);

        // 2: bouncy start key
        do_reset();
        bounce_run = 0;
        for (int i = 0; i < 12; i++) begin
            key_ss_n = ((i / 2) % 2) != 0;
            @(negedge clk);
            if (running) bounce_run++;
        end
        press_keys(1, 0, 0, 25);
        check_eq("t2_no_run_bounce", bounce_run, 0);
        check_eq("t2_run_rise", run_rise_at, 7);
        check_eq("t2_single_press", run_fall_at, -1);
        check_eq("t2_running_end", int'(running), 1);

        // 3: four laps in RUN
        for (int k = 0; k < 4; k++) begin
            press_keys(0, 1, 0, 20);
            check_eq($sformatf("t3_we_count%0d", k), mon_we, 1);
            check_eq($sformatf("t3_idx%0d", k), we_idx, exp_idx[k]);
            check_eq($sformatf("t3_cnt%0d", k), we_cnt, exp_cnt[k]);
        end

        // 5: view validation and clear rules
        do_reset();
        press_keys(1, 0, 0, 20);
        press_keys(0, 1, 0, 20);
        sw_view = 2'd2;
        repeat (2) @(negedge clk);
        check_eq("t5_view2_cnt1", int'(disp_sel), 0);
        sw_view = 2'd1;
        repeat (2) @(negedge clk);
        check_eq("t5_view1_cnt1", int'(disp_sel), 1);
        press_keys(0, 1, 0, 20);
        sw_view = 2'd2;
        repeat (2) @(negedge clk);
        check_eq("t5_view2_cnt2", int'(disp_sel), 2);
        sw_view = 2'd3;
        repeat (2) @(negedge clk);
        check_eq("t5_view3_cnt2", int'(disp_sel), 0);
        sw_view = 2'd2;
        press_keys(0, 0, 1, 20);
        check_eq("t5_clr_run_pulse", mon_clr, 0);
        check_eq("t5_clr_run_state", int'(running), 1);
        check_eq("t5_clr_run_cnt", int'(lap_cnt), 2);
        press_keys(1, 0, 0, 20);
        check_eq("t5_stop", run_fall_at, 7);
        press_keys(1, 0, 1, 20);
        check_eq("t5_ssclr_rise", run_rise_at, 7);
        check_eq("t5_ssclr_pulse", mon_clr, 0);
        check_eq("t5_ssclr_cnt", int'(lap_cnt), 2);
        press_keys(1, 0, 0, 20);
        press_keys(0, 0, 1, 20);
        check_eq("t5_clr_pulse", mon_clr, 1);
        check_eq("t5_clr_cnt", int'(lap_cnt), 0);
        check_eq("t5_clr_state", int'(running), 0);
        check_eq("t5_clr_disp", int'(disp_sel), 0);
        press_keys(1, 0, 0, 20);
        press_keys(1, 1, 0, 20);
        check_eq("t5_sslap_we", mon_we, 1);
        check_eq("t5_sslap_idx", we_idx, 0);
        check_eq("t5_sslap_run", run_at_we, 0);
        check_eq("t5_sslap_fall", run_fall_at, 7);

        // 6: asynchronous reset mid-RUN
        do_reset();
        sw_view = 2'd0;
        press_keys(1, 0, 0, 20);
        press_keys(0, 1, 0, 20);
        press_keys(0, 1, 0, 20);
        check_eq("t6_pre_cnt", int'(lap_cnt), 2);
        check_eq("t6_pre_run", int'(running), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_async_outs", all_outs(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("t6_idle", int'(running), 0);
        press_keys(1, 0, 0, 20);
        check_eq("t6_rise", run_rise_at, 7);
        press_keys(0, 1, 0, 20);
        check_eq("t6_first_idx", we_idx, 0);
        check_eq("t6_first_cnt", we_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
